adc_spi_rx: RTL and testbench

ADC_SPI_RX -- requirements
Module: adc_spi_rx

---
 rtl/adc_spi_rx.sv | 194 +++++++++++++++++++
 tb/tb_adc_spi_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: SPI slave receiver for a free-running ADC master.
//
// Captures fixed-length frames of CHANNELS words (WORD_BITS each, MSB first)
// from an asynchronous SPI link and commits them atomically to o_Channel_Data.
// All SPI inputs are oversampled by i_Clock through synchronisers; no logic
// runs on the SPI clock itself.
//
// Ports:
//   i_Clock        system clock, all logic on its rising edge
//   i_Reset        synchronous active-high reset
//   i_ADC_Clock    SPI SCK (async, idle low)
//   i_ADC_Data     SPI MOSI (async, changes on SCK fall)
//   i_ADC_CS       SPI chip select (async, active low)
//   o_Channel_Data last committed frame, channel n at [n*WORD_BITS +: WORD_BITS]
//   o_Word_Valid   one-cycle pulse per completed in-range word
//   o_Word_Index   channel index of the flagged word
//   o_Word_Data    value of the flagged word
//   o_Frame_Valid  one-cycle pulse when a well-formed frame commits
//   o_Frame_Error  one-cycle pulse when a malformed frame is discarded
//   o_Busy         high while a frame is being received or checked
module adc_spi_rx #(
    parameter int WORD_BITS   = 16,
    parameter int CHANNELS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_ADC_Clock,
    input  logic                          i_ADC_Data,
    input  logic                          i_ADC_CS,
    output logic [CHANNELS*WORD_BITS-1:0] o_Channel_Data,
    output logic                          o_Word_Valid,
    output logic [3:0]                    o_Word_Index,
    output logic [WORD_BITS-1:0]          o_Word_Data,
    output logic                          o_Frame_Valid,
    output logic                          o_Frame_Error,
    output logic                          o_Busy
);

    localparam int BCW = $clog2(WORD_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] flush_sr;
    logic                   sck_prev;
    logic                   cs_prev;
    logic                   armed;
    logic                   overflow;
    logic [BCW-1:0]         bit_cnt;
    logic [4:0]             word_cnt;
    logic [WORD_BITS-1:0]   shift_reg;
    logic [WORD_BITS-1:0]   staging [CHANNELS];
    logic [CHANNELS*WORD_BITS-1:0] staging_flat;

    logic sck_s, mosi_s, cs_s;
    logic sck_rise, cs_rise, cs_fall;
    logic frame_ok;
    logic [WORD_BITS-1:0] new_word;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign new_word = {shift_reg[WORD_BITS-2:0], mosi_s};
    assign frame_ok = (word_cnt == 5'(CHANNELS)) && (bit_cnt == '0) && !overflow;

    // NOTE: combinational logic uses blocking assignments, with a default
    // written first so no latch is inferred.
    always_comb begin
        staging_flat = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            staging_flat[n*WORD_BITS +: WORD_BITS] = staging[n];
        end
    end

    // Synchronisers reset to the idle line levels so reset itself never
    // looks like an SPI edge.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_ADC_Clock};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_ADC_Data};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_ADC_CS};
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= IDLE;
            sck_prev       <= 1'b0;
            cs_prev        <= 1'b1;
            flush_sr       <= '0;
            armed          <= 1'b0;
            overflow       <= 1'b0;
            bit_cnt        <= '0;
            word_cnt       <= '0;
            shift_reg      <= '0;
            // NOTE: the staging array is a handful of flops, not a RAM, so it
            // is cleared explicitly and reads as zero after reset.
            for (int n = 0; n < CHANNELS; n++) staging[n] <= '0;
            o_Channel_Data <= '0;
            o_Word_Valid   <= 1'b0;
            o_Word_Index   <= '0;
            o_Word_Data    <= '0;
            o_Frame_Valid  <= 1'b0;
            o_Frame_Error  <= 1'b0;
            o_Busy         <= 1'b0;
        end else begin
            o_Word_Valid  <= 1'b0;
            o_Frame_Valid <= 1'b0;
            o_Frame_Error <= 1'b0;
            sck_prev      <= sck_s;
            cs_prev       <= cs_s;

            // Only once the synchronisers hold real line values, and CS has
            // been seen high, may a CS fall start a frame. This stops a CS
            // held low across reset from opening a frame mid-stream.
            flush_sr <= {flush_sr[SYNC_STAGES-2:0], 1'b1};
            if (flush_sr[SYNC_STAGES-1] && cs_s) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (armed && cs_fall) begin
                        state    <= SHIFT;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        o_Busy   <= 1'b1;
                    end
                end

                SHIFT: begin
                    // CS rise takes priority over a coincident SCK rise.
                    if (cs_rise) begin
                        state <= CHECK;
                    end else if (sck_rise) begin
                        shift_reg <= new_word;
                        if (bit_cnt == BCW'(WORD_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (word_cnt < 5'(CHANNELS)) begin
                                for (int n = 0; n < CHANNELS; n++) begin
                                    if (word_cnt == 5'(n)) staging[n] <= new_word;
                                end
                                o_Word_Valid <= 1'b1;
                                o_Word_Index <= word_cnt[3:0];
                                o_Word_Data  <= new_word;
                                word_cnt     <= word_cnt + 5'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                CHECK: begin
                    if (frame_ok) begin
                        o_Channel_Data <= staging_flat;
                        o_Frame_Valid  <= 1'b1;
                    end else begin
                        o_Frame_Error <= 1'b1;
                    end
                    // A new frame may already be starting; do not lose it.
                    if (cs_fall) begin
                        state    <= SHIFT;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        o_Busy <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_rx.sv
// tb_adc_spi_rx: self-checking bench for adc_spi_rx.
// A frame-level model predicts word pulses, frame outcomes and the committed
// frame; one compare process checks the DUT against it every cycle, and
// literal expectations pin the model at key points.
`timescale 1ns/1ps
module tb_adc_spi_rx;

    localparam real HALF_CLK = 10.417;   // ~48 MHz
    localparam int  HALF_SCK = 375;      // 750 ns SCK

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0, mosi = 1'b0, cs = 1'b1;
    logic [79:0] ch_data;
    logic        word_valid, frame_valid, frame_error, busy;
    logic [3:0]  word_index;
    logic [15:0] word_data;

    logic        sck2 = 1'b0, mosi2 = 1'b0, cs2 = 1'b1;
    logic [35:0] ch_data2;
    logic        word_valid2, frame_valid2, frame_error2, busy2;
    logic [3:0]  word_index2;
    logic [11:0] word_data2;

    always #HALF_CLK clk = ~clk;

    adc_spi_rx dut (
        .i_Clock(clk), .i_Reset(rst), .i_ADC_Clock(sck), .i_ADC_Data(mosi),
        .i_ADC_CS(cs), .o_Channel_Data(ch_data), .o_Word_Valid(word_valid),
        .o_Word_Index(word_index), .o_Word_Data(word_data),
        .o_Frame_Valid(frame_valid), .o_Frame_Error(frame_error), .o_Busy(busy)
    );

    adc_spi_rx #(.WORD_BITS(12), .CHANNELS(3)) dut12 (
        .i_Clock(clk), .i_Reset(rst), .i_ADC_Clock(sck2), .i_ADC_Data(mosi2),
        .i_ADC_CS(cs2), .o_Channel_Data(ch_data2), .o_Word_Valid(word_valid2),
        .o_Word_Index(word_index2), .o_Word_Data(word_data2),
        .o_Frame_Valid(frame_valid2), .o_Frame_Error(frame_error2), .o_Busy(busy2)
    );

    typedef struct { logic [3:0] idx; logic [15:0] data; } word_t;
    typedef struct { bit ok; logic [79:0] data; } frame_t;

    word_t       word_q[$];
    frame_t      frame_q[$];
    logic [15:0] tx_q[$];
    logic [79:0] model_data = '0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          fv_count = 0;
    int          fe_count = 0;

    int          w12_count = 0, fv12_count = 0, fe12_count = 0;
    logic [11:0] w12_log [3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid) begin
                if (word_q.size() == 0) begin
                    check("unexpected_word_valid", 1, 0);
                end else begin
                    word_t w;
                    w = word_q.pop_front();
                    check("word_index", word_index, w.idx);
                    check("word_data", word_data, w.data);
                end
            end
            if (frame_valid && frame_error) check("valid_and_error_together", 1, 0);
            if (frame_valid || frame_error) begin
                if (frame_valid) fv_count++;
                if (frame_error) fe_count++;
                if (frame_q.size() == 0) begin
                    check("unexpected_frame_pulse", 1, 0);
                end else begin
                    frame_t f;
                    f = frame_q.pop_front();
                    check("frame_outcome_valid", frame_valid, f.ok);
                    if (f.ok) model_data = f.data;
                end
            end
            check("channel_data", ch_data, model_data);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid2) begin
                if (word_index2 < 4'd3) w12_log[word_index2] = word_data2;
                w12_count++;
            end
            if (frame_valid2) fv12_count++;
            if (frame_error2) fe12_count++;
        end
    end

    task automatic send_bits(input logic [15:0] v, input int nb);
        for (int b = nb - 1; b >= 0; b--) begin
            mosi = v[b];
            #HALF_SCK sck = 1'b1;
            #HALF_SCK sck = 1'b0;
        end
    endtask

    // Sends tx_q as one frame (plus extra_bits of extra_val), recording what
    // the receiver must report. short_gap closes the frame with a one-clock
    // CS-high blip so the next frame starts while the DUT is checking.
    task automatic send_frame(input int extra_bits, input logic [15:0] extra_val,
                              input bit short_gap);
        int     n = tx_q.size();
        frame_t f;
        int     lat;
        for (int i = 0; i < n && i < 5; i++) word_q.push_back('{idx: 4'(i), data: tx_q[i]});
        f.ok   = (n == 5) && (extra_bits == 0);
        f.data = '0;
        for (int i = 0; i < 5 && i < n; i++) f.data[i*16 +: 16] = tx_q[i];
        frame_q.push_back(f);

        cs = 1'b0;
        #HALF_SCK;
        for (int i = 0; i < n; i++) send_bits(tx_q[i], 16);
        if (extra_bits > 0) send_bits(extra_val, extra_bits);
        #HALF_SCK;
        @(posedge clk) #1 cs = 1'b1;
        if (short_gap) begin
            @(posedge clk) #1 cs = 1'b0;
        end else begin
            lat = 0;
            for (int k = 1; k <= 20 && lat == 0; k++) begin
                @(posedge clk) #1;
                if (frame_valid || frame_error) lat = k;
            end
            check("frame_latency_in_window", (lat >= 3 && lat <= 5), 1);
            #(4 * HALF_SCK);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((busy || frame_q.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        check({name, "_settled"}, (k < 200), 1);
        check({name, "_words_all_seen"}, word_q.size(), 0);
    endtask

    task automatic send12(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        logic [11:0] w [3];
        w[0] = a; w[1] = b; w[2] = c;
        cs2 = 1'b0;
        #HALF_SCK;
        for (int i = 0; i < 3; i++) begin
            for (int j = 11; j >= 0; j--) begin
                mosi2 = w[i][j];
                #HALF_SCK sck2 = 1'b1;
                #HALF_SCK sck2 = 1'b0;
            end
        end
        #HALF_SCK cs2 = 1'b1;
        #(4 * HALF_SCK);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_channel_data", ch_data, 80'h0);
        check("rst_busy", busy, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_frame_pulses", {frame_valid, frame_error}, 2'b00);
        check("rst_word_out", {word_index, word_data}, 20'h0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Frame A: reference frame.
        tx_q = '{16'h007B, 16'h0067, 16'h01FA, 16'h0000, 16'h0000};
        send_frame(0, 16'h0, 0);
        wait_idle("frameA");
        check("frameA_literal", ch_data, 80'h0000_0000_01FA_0067_007B);

        // Short frame of four words.
        tx_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        send_frame(0, 16'h0, 0);
        wait_idle("short");
        check("short_keeps_A", ch_data, 80'h0000_0000_01FA_0067_007B);

        // Six words: the extra one must be dropped silently.
        tx_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
        send_frame(0, 16'h0, 0);
        wait_idle("six");
        check("six_keeps_A", ch_data, 80'h0000_0000_01FA_0067_007B);

        // Five words plus three stray bits, then a good frame B.
        tx_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
        send_frame(3, 16'h0005, 0);
        wait_idle("partial");
        check("partial_keeps_A", ch_data, 80'h0000_0000_01FA_0067_007B);
        tx_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F};
        send_frame(0, 16'h0, 0);
        wait_idle("frameB");
        check("frameB_literal", ch_data, 80'h0F0F_DEF0_9ABC_5678_1234);

        // Reset after two words, CS held low across reset.
        word_q.push_back('{idx: 4'd0, data: 16'hC0DE});
        word_q.push_back('{idx: 4'd1, data: 16'hBEEF});
        cs = 1'b0;
        #HALF_SCK;
        send_bits(16'hC0DE, 16);
        send_bits(16'hBEEF, 16);
        send_bits(16'h0015, 5);
        #HALF_SCK;
        check("pre_reset_words_seen", word_q.size(), 0);
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1;
        model_data = '0;
        frame_q.delete();
        word_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_channel_data", ch_data, 80'h0);
        check("midrst_busy", busy, 0);
        check("midrst_pulses", {word_valid, frame_valid, frame_error}, 3'b000);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        send_bits(16'hFFFF, 16);      // CS still low: must be ignored
        #HALF_SCK;
        check("cs_low_after_reset_idle", busy, 0);
        cs = 1'b1;
        #(4 * HALF_SCK);
        check("after_reset_no_pulses", fv_count * 16 + fe_count, 5 * 0 + 16 * 2 + 3);
        tx_q = '{16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04, 16'h0C05};
        send_frame(0, 16'h0, 0);
        wait_idle("frameC");
        check("frameC_literal", ch_data, 80'h0C05_0C04_0C03_0C02_0C01);

        // Back-to-back frames D and E: E starts while D is being checked.
        tx_q = '{16'hD000, 16'hD001, 16'hD002, 16'hD003, 16'hD004};
        send_frame(0, 16'h0, 1);
        tx_q = '{16'hE000, 16'hE001, 16'hE002, 16'hE003, 16'hE004};
        send_frame(0, 16'h0, 0);
        wait_idle("frameE");
        check("frameE_literal", ch_data, 80'hE004_E003_E002_E001_E000);
        check("total_frame_valid", fv_count, 5);
        check("total_frame_error", fe_count, 3);

        // Narrow configuration.
        send12(12'hABC, 12'h123, 12'hFFF);
        check("w12_data", ch_data2, 36'hFFF123ABC);
        check("w12_frame_valid", fv12_count, 1);
        check("w12_frame_error", fe12_count, 0);
        check("w12_words", w12_count, 3);
        check("w12_word_values", {w12_log[2], w12_log[1], w12_log[0]}, 36'hFFF123ABC);
        check("w12_idle", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
